// File: rtl/svc_rv_ienc.sv
// RV32I instruction encoder: turns an operation kind plus fields into one registered
// 32-bit instruction word, expanding the LI pseudo-op into LUI/ADDI when needed.
module svc_rv_ienc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err,
  output logic [7:0]      err_cnt
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] K_LOAD   = 4'd0;
  localparam logic [3:0] K_STORE  = 4'd1;
  localparam logic [3:0] K_RTYPE  = 4'd2;
  localparam logic [3:0] K_BRANCH = 4'd3;
  localparam logic [3:0] K_ITYPE  = 4'd4;
  localparam logic [3:0] K_JAL    = 4'd5;
  localparam logic [3:0] K_AUIPC  = 4'd6;
  localparam logic [3:0] K_LUI    = 4'd7;
  localparam logic [3:0] K_JALR   = 4'd8;
  localparam logic [3:0] K_LI     = 4'd9;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_ITYPE  = 7'h13;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic signed [31:0] I_MIN = -32'sd2048;
  localparam logic signed [31:0] I_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN = -32'sd4096;
  localparam logic signed [31:0] B_MAX = 32'sd4094;
  localparam logic signed [31:0] J_MIN = -32'sd1048576;
  localparam logic signed [31:0] J_MAX = 32'sd1048574;

  typedef enum logic {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [ILEN-1:0]   out_instr_q, out_instr_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ILEN-1:0]   lo_instr_q, lo_instr_d;

  logic [31:0]        imm;
  logic signed [31:0] imm_s;
  logic [31:0]        li_sum;
  logic               fits_i, fits_b, fits_j;
  logic [ILEN-1:0]    enc_instr_c;
  logic               enc_err_c;
  logic               enc_two_c;
  logic [ILEN-1:0]    enc_lo_c;
  logic               slot_free_c;
  logic               accept_c;

  assign imm    = in_imm[31:0];
  assign imm_s  = $signed(imm);
  assign li_sum = imm + 32'h0000_0800;
  assign fits_i = (imm_s >= I_MIN) && (imm_s <= I_MAX);
  assign fits_b = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !imm[0];
  assign fits_j = (imm_s >= J_MIN) && (imm_s <= J_MAX) && !imm[0];

  assign slot_free_c = !out_valid_q || out_ready;
  assign in_ready    = (state_q == IDLE) && slot_free_c;
  assign accept_c    = in_valid && in_ready;

  // Field packing; out-of-range immediates still pack their truncated low bits.
  always_comb begin
    enc_instr_c = '0;
    enc_err_c   = 1'b0;
    enc_two_c   = 1'b0;
    enc_lo_c    = '0;
    unique case (in_op)
      K_LOAD: begin
        enc_instr_c = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        enc_err_c   = !fits_i;
      end
      K_STORE: begin
        enc_instr_c = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], OPC_STORE};
        enc_err_c   = !fits_i;
      end
      K_RTYPE: begin
        enc_instr_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_RTYPE};
      end
      K_BRANCH: begin
        enc_instr_c = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3,
                       imm[4:1], imm[11], OPC_BRANCH};
        enc_err_c   = !fits_b;
      end
      K_ITYPE: begin
        enc_instr_c = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_ITYPE};
        enc_err_c   = !fits_i;
      end
      K_JAL: begin
        enc_instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, OPC_JAL};
        enc_err_c   = !fits_j;
      end
      K_AUIPC: begin
        enc_instr_c = {imm[31:12], in_rd, OPC_AUIPC};
        enc_err_c   = (imm[11:0] != 12'd0);
      end
      K_LUI: begin
        enc_instr_c = {imm[31:12], in_rd, OPC_LUI};
        enc_err_c   = (imm[11:0] != 12'd0);
      end
      K_JALR: begin
        enc_instr_c = {imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
        enc_err_c   = !fits_i;
      end
      K_LI: begin
        if (fits_i) begin
          enc_instr_c = {imm[11:0], 5'd0, 3'b000, in_rd, OPC_ITYPE};
        end else begin
          // Upper part is rounded so the sign-extended low ADDI lands on the value.
          enc_instr_c = {li_sum[31:12], in_rd, OPC_LUI};
          enc_two_c   = (imm[11:0] != 12'd0);
          enc_lo_c    = {imm[11:0], in_rd, 3'b000, in_rd, OPC_ITYPE};
        end
      end
      default: begin
        enc_instr_c = '0;
        enc_err_c   = 1'b1;
      end
    endcase
  end

  // Next-state and output slot update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    lo_instr_d  = lo_instr_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_instr_c;
          out_err_d   = enc_err_c;
          if (enc_err_c && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (enc_two_c) begin
            state_d    = LI_LO;
            lo_instr_d = enc_lo_c;
          end
        end
      end
      LI_LO: begin
        if (slot_free_c) begin
          out_valid_d = 1'b1;
          out_instr_d = lo_instr_q;
          out_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      lo_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      lo_instr_q  <= lo_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_svc_rv_ienc.sv
// Bench for svc_rv_ienc: directed vector table, stall/reset sequences and random
// traffic scored against a queue-based reference encoder.
module tb_svc_rv_ienc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  svc_rv_ienc #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    int          nw;
    logic [31:0] w0, w1;
    logic        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Expected-state model: the output slot plus words still waiting to enter it.
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic        m_err   = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_pend[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint fld(input longint x, input int lo, input int nb);
    return (x >> lo) & ((64'd1 << nb) - 64'd1);
  endfunction

  function automatic bit inr(input longint v, input longint lo, input longint hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic longint itw(input longint v, input longint rs1, input longint f3,
                                 input longint rd, input longint opc);
    return (fld(v, 0, 12) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  // Reference encoder computed from the instruction-format tables.
  function automatic void ref_enc(input req_t r, output int n, output logic [31:0] w0,
                                  output logic [31:0] w1, output logic e);
    longint v, u, rd, rs1, rs2, f3, f7, hi, lo, w;
    v   = longint'($signed(r.imm));
    u   = longint'(r.imm);
    rd  = longint'(r.rd);
    rs1 = longint'(r.rs1);
    rs2 = longint'(r.rs2);
    f3  = longint'(r.f3);
    f7  = longint'(r.f7);
    n = 1; e = 1'b0; w1 = '0; w = 0;
    case (r.op)
      4'd0: begin w = itw(v, rs1, f3, rd, 64'h03); e = !inr(v, -2048, 2047); end
      4'd1: begin
        w = (fld(v, 5, 7) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (fld(v, 0, 5) << 7) | 64'h23;
        e = !inr(v, -2048, 2047);
      end
      4'd2: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 64'h33;
      4'd3: begin
        w = (fld(v, 12, 1) << 31) | (fld(v, 5, 6) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | (fld(v, 1, 4) << 8) | (fld(v, 11, 1) << 7) | 64'h63;
        e = !inr(v, -4096, 4094) || ((v & 1) != 0);
      end
      4'd4: begin w = itw(v, rs1, f3, rd, 64'h13); e = !inr(v, -2048, 2047); end
      4'd5: begin
        w = (fld(v, 20, 1) << 31) | (fld(v, 1, 10) << 21) | (fld(v, 11, 1) << 20)
          | (fld(v, 12, 8) << 12) | (rd << 7) | 64'h6F;
        e = !inr(v, -1048576, 1048574) || ((v & 1) != 0);
      end
      4'd6: begin w = (u & 64'hFFFF_F000) | (rd << 7) | 64'h17; e = (u & 64'hFFF) != 0; end
      4'd7: begin w = (u & 64'hFFFF_F000) | (rd << 7) | 64'h37; e = (u & 64'hFFF) != 0; end
      4'd8: begin w = itw(v, rs1, 0, rd, 64'h67); e = !inr(v, -2048, 2047); end
      4'd9: begin
        if (inr(v, -2048, 2047)) begin
          w = itw(v, 0, 0, rd, 64'h13);
        end else begin
          hi = (v + 2048) & 64'hFFFF_F000;
          lo = v & 64'hFFF;
          w  = hi | (rd << 7) | 64'h37;
          if (lo != 0) begin
            n  = 2;
            w1 = 32'((lo << 20) | (rd << 15) | (rd << 7) | 64'h13);
          end
        end
      end
      default: begin w = 0; e = 1'b1; end
    endcase
    w0 = 32'(w);
  endfunction

  function automatic void m_load(input logic [31:0] w, input logic e);
    m_valid = 1'b1;
    m_instr = w;
    m_err   = e;
    if (e && m_cnt < 255) m_cnt++;
  endfunction

  // One clock: drive, check in_ready, advance model, then check registered outputs.
  task automatic step(input logic v, input req_t r, input logic ordy);
    int n; logic [31:0] w0, w1; logic e; logic free, exp_rdy;
    in_valid = v; in_op = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm; out_ready = ordy;
    #1;
    free    = !m_valid || ordy;
    exp_rdy = (m_pend.size() == 0) && free;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_pend.size() != 0 && free) begin
      m_load(m_pend.pop_front(), 1'b0);
    end else if (v && exp_rdy) begin
      ref_enc(r, n, w0, w1, e);
      m_load(w0, e);
      if (n == 2) m_pend.push_back(w1);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_err", 32'(out_err), 32'(m_err));
    end
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  function automatic req_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mv(input req_t r, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic e);
    vec_t t;
    t.r = r; t.nw = nw; t.w0 = w0; t.w1 = w1; t.e = e;
    return t;
  endfunction

  function automatic logic [31:0] rnd_imm();
    logic [31:0] x;
    case ($urandom_range(0, 5))
      0: x = 32'($signed(int'($urandom_range(0, 4200)) - 2100));
      1: x = 32'($signed(int'($urandom_range(0, 10000)) - 5000));
      2: x = 32'($signed(int'($urandom_range(0, 200)) - 100 + 1048576 * (int'($urandom_range(0, 2)) - 1)));
      3: x = $urandom() & 32'hFFFF_F000;
      4: x = ($urandom() & 32'hFFFF_F000) | 32'h800;
      default: x = $urandom();
    endcase
    return x;
  endfunction

  vec_t        vecs[$];
  req_t        idle_r;
  req_t        rr;
  logic [31:0] held;

  initial begin
    idle_r = mk(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    vecs.push_back(mv(mk(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5),          1, 32'h0050_0093, 0, 0));
    vecs.push_back(mv(mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678),  2, 32'h1234_50B7, 32'h6780_8093, 0));
    vecs.push_back(mv(mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5800),  2, 32'h1234_60B7, 32'h8000_8093, 0));
    vecs.push_back(mv(mk(4'd9, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_0000),  1, 32'h0001_0137, 0, 0));
    vecs.push_back(mv(mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8),          1, 32'h0080_00EF, 0, 0));
    vecs.push_back(mv(mk(4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4097),       1, 32'h8000_0063, 0, 1));
    vecs.push_back(mv(mk(4'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFFC),  1, 32'hFFC1_2283, 0, 0));
    vecs.push_back(mv(mk(4'd1, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8),          1, 32'h0051_2423, 0, 0));
    vecs.push_back(mv(mk(4'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0),         1, 32'h4020_81B3, 0, 0));
    vecs.push_back(mv(mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000),  1, 32'h1234_50B7, 0, 0));
    vecs.push_back(mv(mk(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000),  1, 32'h0000_1097, 0, 0));
    vecs.push_back(mv(mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001),  1, 32'h1234_50B7, 0, 1));
    vecs.push_back(mv(mk(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),       1, 32'h8000_0093, 0, 1));
    vecs.push_back(mv(mk(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800),  1, 32'h8000_0093, 0, 0));
    vecs.push_back(mv(mk(4'd8, 5'd1, 5'd5, 5'd0, 3'd3, 7'd0, 32'd4),          1, 32'h0042_80E7, 0, 0));
    vecs.push_back(mv(mk(4'd12, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd4),         1, 32'h0000_0000, 0, 1));
    vecs.push_back(mv(mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9),          1, 32'h0080_00EF, 0, 1));
    vecs.push_back(mv(mk(4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094),       1, 32'h7E00_0FE3, 0, 0));
    vecs.push_back(mv(mk(4'd9, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF),  1, 32'hFFF0_0193, 0, 0));
    vecs.push_back(mv(mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),       2, 32'h0000_10B7, 32'h8000_8093, 0));

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].r, 1'b1);
      chk($sformatf("vec%0d_w0", i), out_instr, vecs[i].w0);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].e));
      if (i == 5) chk("branch_err_cnt", 32'(err_cnt), 32'd1);
      if (vecs[i].nw == 2) begin
        step(1'b0, idle_r, 1'b1);
        chk($sformatf("vec%0d_w1", i), out_instr, vecs[i].w1);
        chk($sformatf("vec%0d_w1_err", i), 32'(out_err), 32'd0);
      end
    end
    step(1'b0, idle_r, 1'b1);

    // Backpressure: held word stays put, new request waits, then flows through.
    step(1'b1, mk(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b1);
    held = out_instr;
    rr = mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    repeat (3) begin
      step(1'b1, rr, 1'b0);
      chk("stall_hold", out_instr, held);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, rr, 1'b1);
    chk("stall_next", out_instr, 32'h0080_00EF);
    step(1'b0, idle_r, 1'b1);

    // Reset while the LI low word is pending.
    step(1'b1, mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678), 1'b0);
    step(1'b0, idle_r, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    m_valid = 1'b0; m_cnt = 0; m_pend.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) step(1'b0, idle_r, 1'b1);

    // Random traffic with random backpressure.
    for (int k = 0; k < 3000; k++) begin
      rr.op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rr.rd  = 5'($urandom()); rr.rs1 = 5'($urandom()); rr.rs2 = 5'($urandom());
      rr.f3  = 3'($urandom()); rr.f7 = 7'($urandom()); rr.imm = rnd_imm();
      step(($urandom_range(0, 3) != 0), rr, ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, idle_r, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svc_rv_ienc.md
SVC_RV_IENC -- requirements
Module: svc_rv_ienc

Interface
REQ-001 SHALL have parameter XLEN, default 32, the register/immediate width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  encode request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_op  input  4  kind: 0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 AUIPC, 7 LUI, 8 JALR, 9 LI (pseudo); 10-15 illegal.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 SHALL have ports in_funct3 (input, 3) and in_funct7 (input, 7), the function fields.
REQ-009 SHALL have port in_imm  input  XLEN  signed byte offset or value; for LUI/AUIPC it is the full value, with bits [11:0] required zero.
REQ-010 SHALL have port out_valid  output  1  encoded word valid.
REQ-011 SHALL have port out_ready  input  1  consumer ready.
REQ-012 SHALL have port out_instr  output  32  encoded RV32I instruction word.
REQ-013 SHALL have port out_err  output  1  qualifies out_instr; the word had a range or opcode error.
REQ-014 SHALL have port err_cnt  output  8  count of words with out_err set, saturating at 255.

Function
REQ-015 SHALL encode standard RV32I formats:
- opcodes: LOAD 0x03, STORE 0x23, RTYPE 0x33, BRANCH 0x63, ITYPE 0x13, JAL 0x6F, AUIPC 0x17, LUI 0x37, JALR 0x67.
- funct3 inserted for LOAD/STORE/RTYPE/BRANCH/ITYPE.
- funct3 is 0 for JALR.
- funct7 inserted only for RTYPE.
REQ-016 SHALL place immediates exactly as the RV32I I/S/B/U/J formats, which is the inverse of the team's instruction decoder imm_i/imm_s/imm_b/imm_u/imm_j extraction.
REQ-017 SHALL flag out_err when the immediate is out of range for its format:
- I/S: not in [-2048, 2047].
- B: not in [-4096, 4094], or odd.
- J: not in [-1048576, 1048574], or odd.
- U: in_imm[11:0] != 0.
REQ-018 SHALL still emit an out-of-range word, with the immediate truncated to its field bits.
REQ-019 SHALL, for an illegal in_op, emit out_instr = 0x00000000 with out_err = 1.
REQ-020 SHALL expand LI into 1 or 2 words:
- imm in [-2048, 2047]: one word, ADDI rd, x0, imm.
- otherwise: LUI rd, hi, where hi = (imm + 0x800)[31:12]; then, if lo = imm[11:0] != 0, ADDI rd, rd, lo (lo sign-extended).
- LI never raises out_err.
REQ-021 SHALL register the output: out_instr/out_err SHALL appear one cycle after acceptance.
REQ-022 SHALL sustain a throughput of one word per cycle.
REQ-023 SHALL hold out_valid, out_instr and out_err stable while out_valid && !out_ready.
REQ-024 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-025 SHALL implement FSM states IDLE and LI_LO:
- IDLE -> LI_LO on accepting an LI that needs two words; the LUI word is loaded and the ADDI word captured internally.
- LI_LO -> IDLE when the output slot frees (!out_valid || out_ready); the ADDI word is loaded at that point.
REQ-026 SHALL deassert in_ready in LI_LO, so a new request is never accepted in the same cycle the ADDI word is loaded.
REQ-027 SHALL clear out_valid on a cycle where out_ready && out_valid and no new word is loaded.
REQ-028 SHALL increment err_cnt by one per accepted output word with out_err = 1, counted at load time and saturating at 255.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force:
- state = IDLE, out_valid = 0, out_instr = 0, out_err = 0, err_cnt = 0.
- in_ready follows REQ-024 and therefore reads 1.
REQ-030 SHALL discard any pending LI ADDI word on reset mid-operation; no partial LI word SHALL appear after reset release.

Verification
REQ-031 SHALL cover: ITYPE rd=1 rs1=0 f3=0 imm=5 -> 0x00500093, out_err=0, one cycle later.
REQ-032 SHALL cover: LI rd=1 imm=0x12345678 with out_ready=1 -> 0x123450B7 then 0x67808093 on consecutive cycles; in_ready=0 for one cycle.
REQ-033 SHALL cover the LI boundaries:
- rd=1 imm=0x12345800 -> 0x123460B7, 0x80008093.
- rd=2 imm=0x00010000 -> single 0x00010137.
REQ-034 SHALL cover: JAL rd=1 imm=8 -> 0x008000EF; BRANCH imm=4097 -> out_err=1 and err_cnt increments to 1.
REQ-035 SHALL cover: out_ready held 0 for 3 cycles with out_valid=1 -> out_instr stable and in_ready=0; release -> next word follows with no loss.
REQ-036 SHALL cover: rst_n low while in LI_LO -> out_valid=0 and err_cnt=0 immediately; after release, no ADDI word is emitted.
